frame_buffer_ctrl: RTL

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

---
 rtl/frame_buffer_ctrl_pkg.sv | 24 ++
 rtl/frame_buffer_ctrl_fifo.sv | 54 +++++
 rtl/frame_buffer_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types for the framebuffer controller: FSM encoding,
// write-FIFO entry layout and pixel address arithmetic.
package frame_buffer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] color;
  } fb_entry_t;

  // Byte address of a 16-bit pixel, evaluated at 32 bits
  function automatic logic [31:0] fb_addr(
    input logic [31:0] base,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [31:0] width
  );
    return base + ((32'(x) + width * 32'(y)) << 1);
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_fifo.sv
// Pixel write FIFO: power-of-two depth, registered occupancy count.
// Push when full and pop when empty are ignored.
module fb_write_fifo
  import frame_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fb_entry_t              din,
  input  logic                   pop,
  output fb_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Framebuffer memory arbiter: queued pixel writes, prioritised scanout
// reads, swap barrier. FB_DOUBLE_BUFFER_EN enables front/back buffers.
module frame_buffer_ctrl
  import frame_buffer_ctrl_pkg::*;
#(
  parameter int          FB_WIDTH   = 400,
  parameter int          FB_HEIGHT  = 240,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR0 = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR1 = 32'h0002_EE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fb_x,
  input  logic [15:0] fb_y,
  input  logic [15:0] fb_color,
  input  logic        fb_write,
  input  logic [15:0] scan_x,
  input  logic [15:0] scan_y,
  input  logic        scan_read,
  output logic [15:0] scan_color,
  output logic        scan_valid,
  input  logic        swap,
  output logic        swap_done,
  output logic        front_buffer,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        overflow,
  output logic        busy
);

  localparam logic [15:0] W16 = 16'(FB_WIDTH);
  localparam logic [15:0] H16 = 16'(FB_HEIGHT);
  localparam logic [31:0] W32 = 32'(FB_WIDTH);

  logic [1:0]  state;
  logic        swap_q;
  logic        swap_pend;
  logic        scan_pend;
  logic [31:0] scan_addr;
  logic [31:0] front_base;
  logic [31:0] back_base;
  logic [31:0] rd_addr;
  logic        in_bounds;
  logic        rd_req;
  logic        drained;
  logic        push;
  logic        pop;
  fb_entry_t   fifo_din;
  fb_entry_t   fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign front_base = front_buffer ? BASE_ADDR1 : BASE_ADDR0;
`ifdef FB_DOUBLE_BUFFER_EN
  assign back_base  = front_buffer ? BASE_ADDR0 : BASE_ADDR1;
`else
  assign back_base  = BASE_ADDR0;
`endif

  assign in_bounds = (fb_x < W16) && (fb_y < H16);
  assign push      = fb_write & in_bounds & ~fifo_full;
  assign pop       = (state == ST_WRITE) & mem_ack;
  assign fifo_din  = '{addr:  fb_addr(back_base, fb_x, fb_y, W32),
                       color: fb_color};

  // A fresh scan_read bypasses the pending latch to save a cycle
  assign rd_req  = scan_pend | scan_read;
  assign rd_addr = scan_pend ? scan_addr
                             : fb_addr(front_base, scan_x, scan_y, W32);
  assign drained = (state == ST_IDLE) & fifo_empty & ~scan_pend;
  assign busy    = (fifo_count != '0) | scan_pend | swap_pend
                 | (state != ST_IDLE);

  fb_write_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      swap_q       <= 1'b0;
      swap_pend    <= 1'b0;
      swap_done    <= 1'b0;
      front_buffer <= 1'b0;
      scan_pend    <= 1'b0;
      scan_addr    <= '0;
      scan_color   <= '0;
      scan_valid   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      overflow     <= 1'b0;
    end else begin
      swap_q     <= swap;
      swap_done  <= 1'b0;
      scan_valid <= 1'b0;
      if (fb_write & in_bounds & fifo_full) overflow <= 1'b1;
      if (scan_read & ~scan_pend) begin
        scan_pend <= 1'b1;
        scan_addr <= rd_addr;
      end
      if (swap_pend & drained) begin
        swap_pend <= 1'b0;
        swap_done <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
        front_buffer <= ~front_buffer;
`endif
      end
      if (swap & ~swap_q) swap_pend <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (rd_req) begin
            state    <= ST_READ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
          end else if (~fifo_empty) begin
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fifo_dout.addr;
            mem_wdata <= fifo_dout.color;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            scan_color <= mem_rdata;
            scan_valid <= 1'b1;
            scan_pend  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
